// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data-memory geometry, copy-engine state encoding and mode constants.
package dmem_pkg;
  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/dmem_copy_engine_addr_gen.sv
// dmem_addr_gen: byte index counter, base+index address (modulo 2**AW) and last-byte compare.
module dmem_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_len,
  output logic [AW-1:0] o_idx,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);
  logic [AW-1:0] r_idx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_idx <= '0;
    else if (i_clr) r_idx <= '0;
    else if (i_inc) r_idx <= r_idx + AW'(1);
  assign o_idx  = r_idx;
  assign o_addr = i_base + r_idx;
  assign o_last = (r_idx + AW'(1)) == i_len;
endmodule

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: drives the data-memory port to copy or fill a byte block, one byte per step.
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);
  logic [1:0]    r_state, w_next;
  logic          r_mode;
  logic [AW-1:0] r_src, r_dst, r_len, w_base, w_addr;
  logic [DW-1:0] r_fill, r_data;
  logic          w_accept, w_last;
  assign w_accept = (r_state == ST_IDLE) && start;
  always_comb
    w_next = (r_state == ST_IDLE)  ? (!start ? ST_IDLE : len == '0 ? ST_FINISH :
                                      mode == MODE_COPY ? ST_READ : ST_WRITE) :
             (r_state == ST_READ)  ? ST_WRITE :
             (r_state == ST_WRITE) ? (w_last ? ST_FINISH : r_mode == MODE_COPY ? ST_READ : ST_WRITE) :
                                     ST_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= mode;
        r_src  <= src;
        r_dst  <= dst;
        r_len  <= len;
        r_fill <= fill;
      end
      if (r_state == ST_READ) r_data <= mem_rd;
    end
  // One adder serves both phases: source base while reading, destination otherwise.
  assign w_base = (r_state == ST_READ) ? r_src : r_dst;
  dmem_addr_gen #(.AW(AW)) u_addr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_inc  (r_state == ST_WRITE),
    .i_base (w_base),
    .i_len  (r_len),
    .o_idx  (count),
    .o_addr (w_addr),
    .o_last (w_last)
  );
  assign busy   = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign done   = r_state == ST_FINISH;
  assign mem_we = r_state == ST_WRITE;
  assign mem_a  = busy ? w_addr : '0;
  assign mem_wd = mem_we ? (r_mode == MODE_FILL ? r_fill : r_data) : '0;
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: directed copy/fill/len0/overlap/restart/reset tests against a byte memory model.
module tb_dmem_copy_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0, fill = '0;
  logic       busy, done, mem_we;
  logic [7:0] count, mem_a, mem_wd, mem_rd;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic       pl_en = 1'b0;
  logic [7:0] pl_a = '0, pl_d = '0;
  int checks = 0;
  int errors = 0;
  int bc, dc, dn, wc, fw;

  always #5 clk = ~clk;

  dmem_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill(fill), .busy(busy), .done(done), .count(count),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a];
  always @(posedge clk)
    if (mem_we) mem[mem_a] <= mem_wd;
    else if (pl_en) mem[pl_a] <= pl_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Launch one operation, scramble the inputs after acceptance, and profile the cycles that follow.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input logic [7:0] f, input int rk,
                        output int o_bc, output int o_dc, output int o_dn, output int o_wc, output int o_fw);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mode = ~m; src = ~s; dst = ~d; len = ~l; fill = ~f;
    o_bc = 0; o_dc = 0; o_dn = 0; o_wc = 0; o_fw = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (busy) o_bc++;
      if (mem_we) begin
        o_wc++;
        if (o_fw == 0) o_fw = k;
      end
      if (done) begin
        o_dn++;
        if (o_dc == 0) o_dc = k;
      end
      start = (k == rk);
      if (k == rk) begin
        mode = 1'b1; src = 8'h20; dst = 8'hB0; len = 8'h02; fill = 8'hEE;
      end
      if (o_dc != 0 && k >= o_dc + 3) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_mem_we", mem_we, 0);
    @(negedge clk) rst = 1'b1;

    poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    run_op(1'b0, 8'h10, 8'h80, 8'h04, 8'h00, 0, bc, dc, dn, wc, fw);
    check("copy_busy_cycles", bc, 8);
    check("copy_done_cycle", dc, 9);
    check("copy_done_pulses", dn, 1);
    check("copy_writes", wc, 4);
    check("copy_first_write", fw, 2);
    check("copy_count", count, 4);
    check("copy_data", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'h11223344);
    check("copy_no_overrun", mem[8'h84], 0);

    poke(8'h01, 8'h77);
    run_op(1'b1, 8'h00, 8'hFE, 8'h03, 8'hA5, 0, bc, dc, dn, wc, fw);
    check("fill_busy_cycles", bc, 3);
    check("fill_done_cycle", dc, 4);
    check("fill_first_write", fw, 1);
    check("fill_count", count, 3);
    check("fill_data_wrap", {mem[8'hFE], mem[8'hFF], mem[8'h00]}, 24'hA5A5A5);
    check("fill_untouched", mem[8'h01], 8'h77);

    poke(8'h90, 8'h33);
    run_op(1'b0, 8'h00, 8'h90, 8'h00, 8'h00, 0, bc, dc, dn, wc, fw);
    check("len0_writes", wc, 0);
    check("len0_done_cycle", dc, 1);
    check("len0_busy_cycles", bc, 0);
    check("len0_count", count, 0);
    check("len0_untouched", mem[8'h90], 8'h33);

    poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03); poke(8'h23, 8'h04);
    run_op(1'b0, 8'h20, 8'h21, 8'h03, 8'h00, 0, bc, dc, dn, wc, fw);
    check("overlap_data", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h01010101);
    check("overlap_done_cycle", dc, 7);

    run_op(1'b0, 8'h10, 8'hA0, 8'h04, 8'h00, 3, bc, dc, dn, wc, fw);
    check("restart_data", {mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]}, 32'h11223344);
    check("restart_ignored", mem[8'hB0], 0);
    check("restart_done_pulses", dn, 1);
    check("restart_done_cycle", dc, 9);
    check("restart_count", count, 4);

    @(negedge clk);
    mode = 1'b1; dst = 8'h40; len = 8'h04; fill = 8'h5A; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_we", mem_we, 1);
    check("abort_pre_addr", mem_a, 8'h41);
    #1 rst = 1'b0;
    #1 check("abort_we_async", mem_we, 0);
    @(negedge clk);
    rst = 1'b1;
    check("abort_first_byte", mem[8'h40], 8'h5A);
    check("abort_second_byte", mem[8'h41], 0);
    dn = 0; bc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bc++;
    end
    check("abort_busy", bc, 0);
    check("abort_no_done", dn, 0);
    check("abort_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
